// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one radix-2 step per cycle, with a single-cycle writeback strobe at completion.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_write
);

  localparam int              CW        = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic            is_div_s, div_zero_s, ovf_s, neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, special_val_s;

  // Accept-side decode: signedness, magnitudes, result sign and special cases.
  always_comb begin
    case (funct3)
      F_MULH, F_DIV, F_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s    = a_signed_s & rs1_data[XLEN-1];
    b_neg_s    = b_signed_s & rs2_data[XLEN-1];
    a_mag_s    = a_neg_s ? neg_w(rs1_data) : rs1_data;
    b_mag_s    = b_neg_s ? neg_w(rs2_data) : rs2_data;
    is_div_s   = funct3[2];
    div_zero_s = is_div_s & (rs2_data == ZERO);
    ovf_s      = is_div_s & a_signed_s & (rs1_data == MIN_INT) & (rs2_data == ALL_ONES);
    // Remainder takes the dividend's sign; products and quotients the XOR.
    if (is_div_s && funct3[1]) begin
      neg_s = a_neg_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    if (div_zero_s) begin
      special_val_s = funct3[1] ? rs1_data : ALL_ONES;
    end else if (funct3[1]) begin
      special_val_s = ZERO;
    end else begin
      special_val_s = MIN_INT;
    end
  end

  logic [XLEN:0]     mul_sum_s, div_diff_s;
  logic [2*XLEN-1:0] step_s;

  // One radix-2 step; acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : ZERO)};
    div_diff_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff_s[XLEN]) begin
        step_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        step_s = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val_s;

  // Sign correction and result selection for the FIX state.
  always_comb begin
    prod_s = neg_q ? neg_dw(acc_q) : acc_q;
    quo_s  = neg_q ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = neg_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (special_q) begin
      fix_val_s = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        F_MUL:                     fix_val_s = prod_s[XLEN-1:0];
        F_MULH, F_MULHSU, F_MULHU: fix_val_s = prod_s[2*XLEN-1:XLEN];
        F_DIV, F_DIVU:             fix_val_s = quo_s;
        F_REM, F_REMU:             fix_val_s = rem_s;
        default:                   fix_val_s = ZERO;
      endcase
    end
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          rd_d  = rd_in;
          neg_d = neg_s;
          cnt_d = {CW{1'b0}};
          if (div_zero_s || ovf_s) begin
            special_d = 1'b1;
            acc_d     = {ZERO, special_val_s};
            state_d   = S_FIX;
          end else begin
            special_d = 1'b0;
            state_d   = S_CALC;
            if (is_div_s) begin
              opnd_d = b_mag_s;
              acc_d  = {ZERO, a_mag_s};
            end else begin
              opnd_d = a_mag_s;
              acc_d  = {ZERO, b_mag_s};
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = step_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        result_d = fix_val_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 3'b000;
      rd_q      <= 5'd0;
      opnd_q    <= ZERO;
      acc_q     <= {2*XLEN{1'b0}};
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign rd_out   = rd_q;
  assign wb_write = done & (rd_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected writebacks are queued at issue
// and compared by a monitor whenever the unit signals done.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, wb_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_write(wb_write)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    p   = 64'h0;
    case (f)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sbv;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sbv;
        return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Scoreboard monitor: every done pops one expected writeback.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_done: got done with result=%h rd_out=%0d, expected no completion", result, rd_out);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (result !== mon_e.res) begin
          errors++; $display("FAIL sb_result: got %h expected %h", result, mon_e.res);
        end
        checks++;
        if (rd_out !== mon_e.rd) begin
          errors++; $display("FAIL sb_rd_out: got %0d expected %0d", rd_out, mon_e.rd);
        end
        checks++;
        if (wb_write !== (mon_e.rd != 5'd0)) begin
          errors++; $display("FAIL sb_wb_write: got %b expected %b", wb_write, (mon_e.rd != 5'd0));
        end
      end
    end
  end

  // Accept at the next edge (E0), push expectation, scramble inputs afterwards.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    exp_t e;
    @(negedge clock);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    e.res = ref_model(f, a, b);
    e.rd  = rd;
    sb_q.push_back(e);
    lat = exp_latency(f, a, b);
    @(posedge clock);
    #1;
    start = 1'b0; funct3 = ~f; rs1_data = $urandom; rs2_data = $urandom; rd_in = ~rd;
  endtask

  // Counts edges after E0 until done is seen (bounded).
  task automatic wait_done(input int n0, output int n, output bit seen);
    n = n0; seen = 1'b0;
    while (!seen && n < n0 + 60) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL reset_wb_write: got %b expected 0", wb_write); end
    checks++; if (result !== 32'h0)  begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0)   begin errors++; $display("FAIL reset_rd_out: got %0d expected 0", rd_out); end
    start = 1'b0; reset = 1'b1;
  endtask

  task automatic test_ops(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    int lat, n; bit seen;
    issue(f, a, b, rd, lat);
    wait_done(0, n, seen);
    checks++;
    if (!seen || n != lat) begin
      errors++; $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", name, n, seen, lat);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || wb_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_pulse_end: got done=%b wb=%b busy=%b expected 0 0 0", name, done, wb_write, busy);
    end
  endtask

  task automatic test_directed();
    test_ops("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5);
    test_ops("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6);
    test_ops("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7);
    test_ops("mulhsu_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8);
    test_ops("div_neg",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9);
    test_ops("rem_neg",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10);
    test_ops("divu",       3'd5, 32'd100,        32'd7,         5'd11);
    test_ops("remu",       3'd7, 32'd100,        32'd7,         5'd12);
  endtask

  task automatic test_special();
    test_ops("divu_zero",  3'd5, 32'd5,          32'h0,         5'd13);
    test_ops("rem_zero",   3'd6, 32'd5,          32'h0,         5'd14);
    test_ops("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15);
    test_ops("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16);
  endtask

  task automatic test_busy_ignore();
    int lat, n, dones; bit seen;
    issue(3'd0, 32'h0001_2345, 32'h0000_0678, 5'd9, lat);
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'd50; rs2_data = 32'd0; rd_in = 5'd3;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(5, n, seen);
    checks++;
    if (!seen || n != lat) begin
      errors++; $display("FAIL busy_ignore_latency: got %0d edges (seen=%b) expected %0d", n, seen, lat);
    end
    dones = 0;
    repeat (45) begin
      @(negedge clock);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL busy_ignore_extra_done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_mid_reset();
    int lat, n, dones; bit seen;
    issue(3'd0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7, lat);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL midreset_rd_out: got %0d expected 0", rd_out); end
    sb_q.delete();
    reset = 1'b1;
    dones = 0;
    repeat (45) begin
      @(negedge clock);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones);
    end
    issue(3'd0, 32'd3, 32'd4, 5'd1, lat);
    wait_done(0, n, seen);
    checks++;
    if (!seen || n != lat) begin
      errors++; $display("FAIL midreset_rerun_latency: got %0d edges (seen=%b) expected %0d", n, seen, lat);
    end
  endtask

  task automatic test_rd_zero();
    int lat, n; bit seen;
    issue(3'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd0, lat);
    wait_done(0, n, seen);
    checks++;
    if (!seen || wb_write !== 1'b0) begin
      errors++; $display("FAIL rd_zero_wb: got done_seen=%b wb_write=%b expected 1 0", seen, wb_write);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat, n; bit seen;
    exp_t e;
    issue(3'd4, 32'd1000, 32'hFFFF_FFF9, 5'd20, lat);
    wait_done(0, n, seen);
    checks++;
    if (!seen || n != lat) begin
      errors++; $display("FAIL b2b_first_latency: got %0d edges expected %0d", n, lat);
    end
    start = 1'b1; funct3 = 3'd7; rs1_data = 32'd1000; rs2_data = 32'd9; rd_in = 5'd21;
    e.res = ref_model(3'd7, 32'd1000, 32'd9); e.rd = 5'd21;
    sb_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy);
    end
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(0, n, seen);
    checks++;
    if (!seen || n != 33) begin
      errors++; $display("FAIL b2b_second_latency: got %0d edges (seen=%b) expected 33", n, seen);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [2:0] f; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      test_ops("random", f, a, b, 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_busy_ignore();
    test_mid_reset();
    test_rd_zero();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits between the register-file read ports and the register-file write port. It takes the `rs1`/`rs2` operand values read from the register file, computes one of the eight M-extension operations over multiple cycles, and presents a single-cycle writeback strobe with `rd` and data for the register-file write port.

## Interface

**Parameters**
- `XLEN`, default 32: operand and result width. Only 32 is supported.

**Ports**
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: request a new operation. Sampled only when `busy`=0.
- `funct3` in 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data` in 32: operand A (register-file read port 1).
- `rs2_data` in 32: operand B (register-file read port 2).
- `rd_in` in 5: destination register index.
- `busy` out 1: operation in progress; high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out 32: final value. Holds its value until the next completion.
- `rd_out` out 5: latched `rd_in`, drives the register-file `rd`.
- `wb_write` out 1: `done & (rd_out != 0)`, drives the register-file `write`.

## Operation

**States and transitions**
- IDLE:
  - `start` → latch operands, `funct3`, `rd_in`.
  - Special case → FIX; otherwise → CALC with 5-bit iteration counter = 0.
- CALC: one radix-2 iteration per cycle. After the 32nd iteration (counter = 31) → FIX.
- FIX: apply sign correction or special-case value, register `result` → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.

**Latching and start handling**
- Operands are latched at accept. Later changes to `rs1_data`/`rs2_data`/`funct3`/`rd_in` have no effect.
- `start` while `busy`=1 is ignored; it is neither queued nor allowed to corrupt state.

**Signedness**
- Operands are converted to magnitudes at accept:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
- `neg` flag:
  - Multiply and quotient: sign(A) XOR sign(B), using the signed operands only.
  - Remainder: sign(A).

**Multiply**
- 64-bit accumulator, shift-add on the magnitudes.
- FIX negates the 64-bit product if `neg` is set.
- MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].

**Divide**
- Restoring division: 33-bit trial subtract of the divisor from the shifted partial remainder each iteration.
- FIX negates the quotient or remainder per `neg`.

**Special cases (skip CALC)**
- Divisor = 0:
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → rs1 unchanged.
- Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF):
  - DIV → 0x80000000.
  - REM → 0.

**Reset**
- Active at any time, including mid-operation: state → IDLE, counter cleared.
- Outputs: `busy`=0, `done`=0, `wb_write`=0, `result`=0, `rd_out`=0.
- An operation interrupted by reset never produces a `done`.

## Timing

- E0 is the rising edge that samples `start`=1 with `busy`=0. `busy` is high from after E0 until after the DONE cycle.
- Normal operation:
  - CALC occupies edges E1..E32; FIX is registered at E33.
  - `done`, `wb_write`, `result` and `rd_out` are valid in the cycle after E33.
  - `busy` falls after E34.
- Special case: FIX at E1; `done` is valid in the cycle after E1; `busy` falls after E2.
- Throughput:
  - The earliest next accept is at the edge where `busy`=0 is first seen, i.e. E35 for normal operations.
  - No back-to-back overlap is allowed.
- `result` and `rd_out` are registered, with no combinational path from inputs to outputs.
- `wb_write` is combinational from registered `done` and `rd_out` only.

## Test plan

- MUL: rs1=7, rs2=0xFFFFFFFD (−3), rd=5.
  - `done` one cycle after E33.
  - `result`=0xFFFFFFEB, `rd_out`=5, `wb_write`=1 for exactly one cycle.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide signs:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases (each with `done` in the cycle after E1):
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Control behaviour:
  - Pulse `start` with new operands at E5 while busy → ignored; the first operation's result is unchanged.
  - Assert `reset`=0 at E10 → `busy`=0 after that edge and no `done`. A new MUL 3×4 started afterwards returns 12.
- rd=0: MULU-class operation with rd_in=0 → `done`=1, `wb_write`=0, `result` still correct.
